// File: rtl/lb_stream_sched.sv
// ----------------------------------------------------------------------------
// lb_stream_sched
//   Scheduler for a circular NBANK-bank BRAM line buffer that feeds a
//   (NBANK-1)-row window datapath. It takes a raster pixel stream over
//   valid/ready and produces the bank write strobes and addresses, the shared
//   read strobe and address, and the bank select for the oldest row. A
//   one-entry output slot models the BRAM read latency and lets the
//   downstream stage stall the whole pipeline.
//
// Ports
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   i_start           frame start pulse, honoured only in IDLE
//   i_in_valid        source pixel valid
//   o_in_ready        pixel accepted this cycle when i_in_valid is high
//   o_wr_en           write strobe to bank o_wr_bank at column o_wr_addr
//   o_wr_bank         bank being written
//   o_wr_addr         write column address
//   o_rd_en           read strobe to all banks except o_wr_bank
//   o_rd_addr         read column address
//   o_out_valid       window column valid at BRAM outputs
//   i_out_ready       downstream accepts the window column
//   o_out_top_bank    bank holding the oldest row of the presented column
//   o_busy            high in every state except IDLE
//   o_done            one-cycle pulse at frame end
//   o_row_cnt         rows fully written in the current frame
//
// State table
//   state    | meaning
//   S_IDLE   | waiting for i_start, no transfers
//   S_FILL   | writing the first NBANK-1 rows, no reads
//   S_STREAM | each accepted pixel is written and its column window read
//   S_DRAIN  | no writes, one more row of window columns is read out
//   S_DONE   | one-cycle done pulse, counters cleared on exit
// ----------------------------------------------------------------------------
module lb_stream_sched #(
    parameter int IMG_W = 512,
    parameter int IMG_H = 512,
    parameter int NBANK = 4,
    parameter int AW    = 9,
    parameter int BW    = 2,
    parameter int RW    = 9
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_start,
    input  logic          i_in_valid,
    output logic          o_in_ready,
    output logic          o_wr_en,
    output logic [BW-1:0] o_wr_bank,
    output logic [AW-1:0] o_wr_addr,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr,
    output logic          o_out_valid,
    input  logic          i_out_ready,
    output logic [BW-1:0] o_out_top_bank,
    output logic          o_busy,
    output logic          o_done,
    output logic [RW-1:0] o_row_cnt
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_STREAM,
        S_DRAIN,
        S_DONE
    } state_t;

    localparam logic [AW-1:0] COL_LAST      = AW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST      = RW'(IMG_H - 1);
    localparam logic [RW-1:0] FILL_ROW_LAST = RW'(NBANK - 2);

    state_t        r_state;
    logic [AW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [BW-1:0] r_wr_bank;
    logic [BW-1:0] r_rd_top_bank;
    logic [BW-1:0] r_out_top_bank;
    logic          r_out_valid;
    logic          r_reads_left;

    logic          w_slot_free;
    logic          w_in_ready;
    logic          w_wr_en;
    logic          w_rd_en;
    logic          w_col_last;

    // The output slot can take a new read when it is empty or being drained.
    assign w_slot_free = !r_out_valid || i_out_ready;
    assign w_col_last  = (r_col == COL_LAST);

    always_comb begin
        w_in_ready = 1'b0;
        case (r_state)
            S_FILL:   w_in_ready = 1'b1;
            S_STREAM: w_in_ready = w_slot_free;
            default:  w_in_ready = 1'b0;
        endcase
    end

    assign w_wr_en = i_in_valid && w_in_ready;

    // In STREAM the read of the previous rows is tied to the write of the
    // current pixel; in DRAIN reads run on their own until the last column.
    assign w_rd_en = ((r_state == S_STREAM) && w_wr_en) ||
                     ((r_state == S_DRAIN) && w_slot_free && r_reads_left);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= S_IDLE;
            r_col          <= '0;
            r_row          <= '0;
            r_wr_bank      <= '0;
            r_rd_top_bank  <= '0;
            r_out_top_bank <= '0;
            r_out_valid    <= 1'b0;
            r_reads_left   <= 1'b0;
        end else begin
            if (w_rd_en) begin
                r_out_valid    <= 1'b1;
                r_out_top_bank <= r_rd_top_bank;
            end else if (r_out_valid && i_out_ready) begin
                r_out_valid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_state <= S_FILL;
                    end
                end

                S_FILL: begin
                    if (w_wr_en) begin
                        if (w_col_last) begin
                            r_col     <= '0;
                            r_wr_bank <= r_wr_bank + BW'(1);
                            r_row     <= r_row + RW'(1);
                            if (r_row == FILL_ROW_LAST) begin
                                r_state       <= S_STREAM;
                                r_rd_top_bank <= '0;
                            end
                        end else begin
                            r_col <= r_col + AW'(1);
                        end
                    end
                end

                S_STREAM: begin
                    if (w_wr_en) begin
                        if (w_col_last) begin
                            r_col         <= '0;
                            r_wr_bank     <= r_wr_bank + BW'(1);
                            r_rd_top_bank <= r_rd_top_bank + BW'(1);
                            r_row         <= r_row + RW'(1);
                            if (r_row == ROW_LAST) begin
                                r_state      <= S_DRAIN;
                                r_reads_left <= 1'b1;
                            end
                        end else begin
                            r_col <= r_col + AW'(1);
                        end
                    end
                end

                S_DRAIN: begin
                    if (w_rd_en) begin
                        if (w_col_last) begin
                            r_col        <= '0;
                            r_reads_left <= 1'b0;
                        end else begin
                            r_col <= r_col + AW'(1);
                        end
                    end
                    // Leave only once the final window column has been taken.
                    if (!r_reads_left && !r_out_valid) begin
                        r_state <= S_DONE;
                    end
                end

                S_DONE: begin
                    r_state        <= S_IDLE;
                    r_col          <= '0;
                    r_row          <= '0;
                    r_wr_bank      <= '0;
                    r_rd_top_bank  <= '0;
                    r_out_top_bank <= '0;
                end

                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign o_in_ready     = w_in_ready;
    assign o_wr_en        = w_wr_en;
    assign o_wr_bank      = r_wr_bank;
    assign o_wr_addr      = r_col;
    assign o_rd_en        = w_rd_en;
    assign o_rd_addr      = r_col;
    assign o_out_valid    = r_out_valid;
    assign o_out_top_bank = r_out_top_bank;
    assign o_busy         = (r_state != S_IDLE);
    assign o_done         = (r_state == S_DONE);
    assign o_row_cnt      = r_row;

endmodule

// File: tb/tb_lb_stream_sched.sv
module tb_lb_stream_sched;

    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int NBANK = 4;
    localparam int AW    = 3;
    localparam int BW    = 2;
    localparam int RW    = 3;

    localparam int FILL_WR      = (NBANK - 1) * IMG_W;
    localparam int TOT_WR       = IMG_W * IMG_H;
    localparam int TOT_RD       = (IMG_H - NBANK + 2) * IMG_W;
    localparam int FRAME_BUDGET = 2000;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          wr_en;
    logic [BW-1:0] wr_bank;
    logic [AW-1:0] wr_addr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic          out_valid;
    logic          out_ready;
    logic [BW-1:0] out_top_bank;
    logic          busy;
    logic          done;
    logic [RW-1:0] row_cnt;

    lb_stream_sched #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .NBANK(NBANK),
        .AW(AW), .BW(BW), .RW(RW)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .i_start       (start),
        .i_in_valid    (in_valid),
        .o_in_ready    (in_ready),
        .o_wr_en       (wr_en),
        .o_wr_bank     (wr_bank),
        .o_wr_addr     (wr_addr),
        .o_rd_en       (rd_en),
        .o_rd_addr     (rd_addr),
        .o_out_valid   (out_valid),
        .i_out_ready   (out_ready),
        .o_out_top_bank(out_top_bank),
        .o_busy        (busy),
        .o_done        (done),
        .o_row_cnt     (row_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Transaction-level model: a frame is a count of pixels written, window
    // reads issued and window beats delivered.
    int m_active = 0;
    int m_wr     = 0;
    int m_rd     = 0;
    int m_beats  = 0;
    int done_cnt = 0;

    // Per-frame statistics gathered from the DUT ports.
    int f_wr, f_wr_rd, f_wr_nord, f_drain_rd, f_beats, f_done, f_row_done;
    int f_first_bank, f_first_addr;
    int tops[64];

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic clear_stats();
        f_wr = 0; f_wr_rd = 0; f_wr_nord = 0; f_drain_rd = 0;
        f_beats = 0; f_done = 0; f_row_done = -1;
        f_first_bank = -1; f_first_addr = -1;
        for (int i = 0; i < 64; i++) tops[i] = -1;
    endtask

    task automatic monitor();
        int exp_ov, slot_free, exp_ir, exp_wr, exp_rd, done_ok;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                m_active = 0; m_wr = 0; m_rd = 0; m_beats = 0;
                clear_stats();
            end else begin
                exp_ov    = (m_rd > m_beats) ? 1 : 0;
                slot_free = (exp_ov == 0 || out_ready) ? 1 : 0;
                exp_ir    = (m_active != 0 &&
                             (m_wr < FILL_WR || (m_wr < TOT_WR && slot_free != 0))) ? 1 : 0;
                exp_wr    = (in_valid && exp_ir != 0) ? 1 : 0;
                exp_rd    = (m_active != 0 &&
                             ((exp_wr != 0 && m_wr >= FILL_WR) ||
                              (m_wr == TOT_WR && m_rd < TOT_RD && slot_free != 0))) ? 1 : 0;
                done_ok   = (m_active != 0 && m_beats == TOT_RD && exp_ov == 0) ? 1 : 0;

                chk("in_ready", int'(in_ready), exp_ir);
                chk("wr_en", int'(wr_en), exp_wr);
                if (exp_wr != 0) begin
                    chk("wr_bank", int'(wr_bank), (m_wr / IMG_W) % NBANK);
                    chk("wr_addr", int'(wr_addr), m_wr % IMG_W);
                end
                chk("rd_en", int'(rd_en), exp_rd);
                if (exp_rd != 0)
                    chk("rd_addr", int'(rd_addr), m_rd % IMG_W);
                if (exp_wr != 0 && exp_rd != 0)
                    chk("wr_bank_vs_top", int'(wr_bank),
                        ((m_rd / IMG_W) % NBANK + NBANK - 1) % NBANK);
                chk("out_valid", int'(out_valid), exp_ov);
                if (exp_ov != 0)
                    chk("out_top_bank", int'(out_top_bank), (m_beats / IMG_W) % NBANK);
                if (out_valid && !out_ready)
                    chk("stall_in_ready", int'(in_ready), 0);
                chk("busy", int'(busy), m_active);
                chk("row_cnt", int'(row_cnt), (m_active != 0) ? (m_wr / IMG_W) : 0);
                if (done)
                    chk("done_window", done_ok, 1);

                if (wr_en) begin
                    if (f_wr == 0) begin
                        f_first_bank = int'(wr_bank);
                        f_first_addr = int'(wr_addr);
                    end
                    f_wr++;
                    if (rd_en) f_wr_rd++;
                    else       f_wr_nord++;
                end else if (rd_en) begin
                    f_drain_rd++;
                end
                if (out_valid && out_ready) begin
                    if (f_beats < 64) tops[f_beats] = int'(out_top_bank);
                    f_beats++;
                end
                if (done) begin
                    f_done++;
                    f_row_done = int'(row_cnt);
                end

                if (m_active == 0 && start) begin
                    m_active = 1; m_wr = 0; m_rd = 0; m_beats = 0;
                    clear_stats();
                end else if (m_active != 0) begin
                    if (exp_wr != 0) m_wr++;
                    if (exp_rd != 0) m_rd++;
                    if (exp_ov != 0 && out_ready) m_beats++;
                    if (done) begin
                        m_active = 0;
                        done_cnt++;
                    end
                end
            end
        end
    endtask

    task automatic rst_checks(input string tag);
        chk({tag, "_in_ready"}, int'(in_ready), 0);
        chk({tag, "_wr_en"}, int'(wr_en), 0);
        chk({tag, "_rd_en"}, int'(rd_en), 0);
        chk({tag, "_out_valid"}, int'(out_valid), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_done"}, int'(done), 0);
        chk({tag, "_row_cnt"}, int'(row_cnt), 0);
        chk({tag, "_wr_bank"}, int'(wr_bank), 0);
        chk({tag, "_wr_addr"}, int'(wr_addr), 0);
        chk({tag, "_rd_addr"}, int'(rd_addr), 0);
        chk({tag, "_out_top"}, int'(out_top_bank), 0);
    endtask

    // Called at posedge+1; start is raised immediately so a call right after
    // the previous frame's done pulse gives a back-to-back frame.
    task automatic run_frame(input int vmode, input int omode, input bit probe, input int rst_wr);
        int d0, cyc;
        bit p1, p2, hit_rst;
        d0 = done_cnt; cyc = 0; p1 = 1'b0; p2 = 1'b0; hit_rst = 1'b0;
        start = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        while (done_cnt == d0 && cyc < FRAME_BUDGET && !hit_rst) begin
            in_valid  = (vmode != 0) ? ($urandom_range(0, 1) == 1) : 1'b1;
            out_ready = (omode != 0) ? (cyc % 2 == 0) : 1'b1;
            start     = 1'b0;
            if (probe && !p1 && m_wr == 30) begin
                start = 1'b1; p1 = 1'b1;
            end else if (probe && !p2 && m_wr == TOT_WR && m_rd < TOT_RD) begin
                start = 1'b1; p2 = 1'b1;
            end
            if (rst_wr >= 0 && m_wr == rst_wr) begin
                #2 rst_n = 1'b0;
                #1 rst_checks("async_rst");
                @(posedge clk);
                @(posedge clk); #1;
                rst_n = 1'b1;
                hit_rst = 1'b1;
            end else begin
                @(posedge clk); #1;
                cyc++;
            end
        end
        start = 1'b0;
        if (!hit_rst) begin
            chk("frame_done_seen", done_cnt - d0, 1);
            chk("frame_writes", f_wr, 48);
            chk("fill_writes_no_rd", f_wr_nord, 24);
            chk("stream_writes_rd", f_wr_rd, 24);
            chk("drain_reads", f_drain_rd, 8);
            chk("out_beats", f_beats, 32);
            chk("done_cycles", f_done, 1);
            chk("row_cnt_at_done", f_row_done, 6);
            chk("first_wr_bank", f_first_bank, 0);
            chk("first_wr_addr", f_first_addr, 0);
            chk("top_beat0", tops[0], 0);
            chk("top_beat7", tops[7], 0);
            chk("top_beat8", tops[8], 1);
            chk("top_beat16", tops[16], 2);
            chk("top_beat24", tops[24], 3);
            chk("top_beat31", tops[31], 3);
        end
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        clear_stats();
        fork
            monitor();
        join_none
        repeat (3) @(posedge clk);
        #1 rst_checks("reset");
        rst_n = 1'b1;
        @(posedge clk); #1;
        rst_checks("idle");

        run_frame(0, 0, 1'b0, -1);   // full rate
        run_frame(0, 1, 1'b0, -1);   // out_ready 1010...
        run_frame(1, 0, 1'b0, -1);   // random input gaps
        run_frame(1, 1, 1'b0, -1);   // gaps plus backpressure
        run_frame(0, 0, 1'b0, 35);   // reset at row 4 col 3
        run_frame(0, 0, 1'b0, -1);   // refill from bank 0 col 0
        run_frame(0, 0, 1'b1, -1);   // start pulsed in STREAM and DRAIN
        run_frame(0, 0, 1'b0, -1);   // back-to-back frame

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
